// File: rtl/nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl
//
// Adds two W = 4*NIBBLES bit operands one nibble per clock, least-significant
// nibble first, using a single 4-bit RippleCarryAdder. The carry between
// nibbles is held in a register, so each addition takes NIBBLES clocks in
// RUN followed by a one-cycle DONE. The result stays put until the next
// accepted start begins overwriting it.
//
// Ports:
//   clk    in   1  rising-edge system clock
//   rst_n  in   1  asynchronous active-low reset
//   start  in   1  request an addition (accepted in IDLE or DONE)
//   a      in   W  operand A, sampled on the accepting edge
//   b      in   W  operand B, sampled on the accepting edge
//   cin    in   1  carry into nibble 0, sampled on the accepting edge
//   busy   out  1  high while an addition is in progress
//   done   out  1  one-cycle pulse when sum/cout are valid
//   sum    out  W  registered result
//   cout   out  1  registered final carry-out
// ---------------------------------------------------------------------------

// 4-bit ripple-carry adder used as the per-nibble arithmetic unit.
module RippleCarryAdder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        Sum  = '0;
        c[0] = Cin;
        for (int i = 0; i < 4; i++) begin
            Sum[i]   = A[i] ^ B[i] ^ c[i];
            c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
        Cout = c[4];
    end

endmodule

module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = $clog2(NIBBLES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    sum_reg;
    logic            cout_reg;
    logic            carry;
    logic [IDXW-1:0] idx;

    logic [3:0]      rca_a;
    logic [3:0]      rca_b;
    logic [3:0]      rca_sum;
    logic            rca_cout;
    logic            accept;
    logic            last_nibble;

    // A start is only honoured when no addition is running; the DONE cycle
    // counts as free so that back-to-back additions need no idle bubble.
    assign accept      = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_nibble = (idx == LAST_IDX);

    // Nibble select as an explicit mux over the legal indices, so idx can
    // never address past the top nibble.
    always_comb begin
        rca_a = '0;
        rca_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDXW'(i)) begin
                rca_a = a_reg[4*i +: 4];
                rca_b = b_reg[4*i +: 4];
            end
        end
    end

    RippleCarryAdder u_rca (
        .A    (rca_a),
        .B    (rca_b),
        .Cin  (carry),
        .Sum  (rca_sum),
        .Cout (rca_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_nibble) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath. sum is not cleared on accept: its nibbles are overwritten
    // one at a time as the new addition progresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            carry    <= 1'b0;
            idx      <= '0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            idx   <= '0;
        end else if (state_q == RUN) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx == IDXW'(i)) begin
                    sum_reg[4*i +: 4] <= rca_sum;
                end
            end
            carry <= rca_cout;
            if (last_nibble) begin
                cout_reg <= rca_cout;
                idx      <= '0;
            end else begin
                idx <= idx + IDXW'(1);
            end
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule
